// File: rtl/esfa_host_controller.sv
`default_nettype none
// ============================================================================
// Module   : esfa_host_controller
// Purpose  : Command/response front end for an ESFA cell array. Accepts
//            write-value, write-metadata and query commands, drives the ESFA
//            write strobe and query selector, and returns captured query
//            results through a valid/ready response channel.
// Options  : ESFA_HOST_STATS_EN - when defined, hit/miss query counters are
//            built; otherwise hit_count_o/miss_count_o are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module esfa_host_controller #(
  parameter int SETTLE_CYCLES = 2   // cycles the selector is held before capture (1..15)
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  // command channel
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_op_i,
  input  logic [7:0] cmd_index_i,
  input  logic [7:0] cmd_data_i,
  input  logic [7:0] cmd_selector_i,
  // response channel
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic       rsp_bool_o,
  output logic [7:0] rsp_value_o,
  output logic       rsp_err_o,
  // ESFA array side
  output logic       esfa_willWrite_o,
  output logic       esfa_isMetadata_o,
  output logic [7:0] esfa_new_index_o,
  output logic [7:0] esfa_new_value_o,
  output logic [7:0] esfa_metadata_o,
  output logic [7:0] esfa_selector_o,
  input  logic       esfa_resultBool_i,
  input  logic [7:0] esfa_resultValue_i,
  // statistics
  output logic [15:0] hit_count_o,
  output logic [15:0] miss_count_o
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [1:0] OP_WVAL  = 2'b00;
  localparam logic [1:0] OP_WMETA = 2'b01;
  localparam logic [1:0] OP_QUERY = 2'b10;

  // Settle count value at which the ESFA result is captured.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  logic [2:0] state_q, state_d;
  logic       init_seen_q, init_seen_d;   // one all-zero result already sampled in INIT
  logic [3:0] settle_cnt_q;

  logic       new_isMeta_q;
  logic [7:0] new_index_q, new_value_q, metadata_q, selector_q;
  logic       rsp_bool_q, rsp_err_q;
  logic [7:0] rsp_value_q;

  logic       accept;
  logic       capture;
  logic       result_zero;

  assign accept      = (state_q == S_IDLE) && cmd_valid_i;
  assign capture     = (state_q == S_SETTLE) && (settle_cnt_q == SETTLE_LAST);
  assign result_zero = !esfa_resultBool_i && (esfa_resultValue_i == 8'h00);

  // State register with asynchronous return to INIT.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_INIT;
      init_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_seen_q <= init_seen_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d     = state_q;
    init_seen_d = 1'b0;
    case (state_q)
      S_INIT: begin
        // Two consecutive all-zero result samples mean the array is quiescent.
        if (result_zero) begin
          if (init_seen_q) state_d = S_IDLE;
          else             init_seen_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_op_i)
            OP_WVAL, OP_WMETA: state_d = S_WRITE;
            OP_QUERY:          state_d = S_SETTLE;
            default:           state_d = S_RESP;
          endcase
        end
      end
      S_WRITE:  state_d = S_IDLE;
      S_SETTLE: if (capture) state_d = S_RESP;
      S_RESP:   if (rsp_ready_i) state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  // State-decoded handshake outputs; combinational so reset clears them at once.
  always_comb begin
    cmd_ready_o      = 1'b0;
    esfa_willWrite_o = 1'b0;
    rsp_valid_o      = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready_o      = 1'b1;
      S_WRITE: esfa_willWrite_o = 1'b1;
      S_RESP:  rsp_valid_o      = 1'b1;
      default: ;
    endcase
  end

  // Command field latching, settle counting and response capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      new_isMeta_q <= 1'b0;
      new_index_q  <= 8'h00;
      new_value_q  <= 8'h00;
      metadata_q   <= 8'h00;
      selector_q   <= 8'h00;
      settle_cnt_q <= 4'd0;
      rsp_bool_q   <= 1'b0;
      rsp_value_q  <= 8'h00;
      rsp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        case (cmd_op_i)
          OP_WVAL: begin
            new_index_q  <= cmd_index_i;
            new_value_q  <= cmd_data_i;
            new_isMeta_q <= 1'b0;
          end
          OP_WMETA: begin
            new_index_q  <= cmd_index_i;
            metadata_q   <= cmd_data_i;
            new_isMeta_q <= 1'b1;
          end
          OP_QUERY: begin
            selector_q   <= cmd_selector_i;
            settle_cnt_q <= 4'd1;
          end
          default: begin
            // Reserved op: canned error response, array untouched.
            rsp_err_q   <= 1'b1;
            rsp_bool_q  <= 1'b0;
            rsp_value_q <= 8'hFF;
          end
        endcase
      end else if (capture) begin
        rsp_bool_q  <= esfa_resultBool_i;
        rsp_value_q <= esfa_resultValue_i;
        rsp_err_q   <= 1'b0;
      end else if (state_q == S_SETTLE) begin
        settle_cnt_q <= settle_cnt_q + 4'd1;
      end
    end
  end

  assign esfa_isMetadata_o = new_isMeta_q;
  assign esfa_new_index_o  = new_index_q;
  assign esfa_new_value_o  = new_value_q;
  assign esfa_metadata_o   = metadata_q;
  assign esfa_selector_o   = selector_q;
  assign rsp_bool_o        = rsp_bool_q;
  assign rsp_value_o       = rsp_value_q;
  assign rsp_err_o         = rsp_err_q;

`ifdef ESFA_HOST_STATS_EN
  logic [15:0] hit_q, miss_q;

  // Saturating hit/miss counters, stepped once per captured query.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      hit_q  <= 16'h0000;
      miss_q <= 16'h0000;
    end else if (capture) begin
      if (esfa_resultBool_i) begin
        if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
      end else begin
        if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      end
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
`else
  assign hit_count_o  = 16'h0000;
  assign miss_count_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_esfa_host_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_esfa_host_controller
// Purpose  : Self-checking bench for esfa_host_controller: table of directed
//            commands plus hand-written backpressure and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esfa_host_controller;

  localparam int SETTLE = 2;
`ifdef ESFA_HOST_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_index, cmd_data, cmd_selector;
  logic       rsp_valid, rsp_ready, rsp_bool, rsp_err;
  logic [7:0] rsp_value;
  logic       esfa_willWrite, esfa_isMetadata;
  logic [7:0] esfa_new_index, esfa_new_value, esfa_metadata, esfa_selector;
  logic       esfa_resultBool;
  logic [7:0] esfa_resultValue;
  logic [15:0] hit_count, miss_count;

  esfa_host_controller #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk_i              (clk),
    .reset_n_i          (reset_n),
    .cmd_valid_i        (cmd_valid),
    .cmd_ready_o        (cmd_ready),
    .cmd_op_i           (cmd_op),
    .cmd_index_i        (cmd_index),
    .cmd_data_i         (cmd_data),
    .cmd_selector_i     (cmd_selector),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_bool_o         (rsp_bool),
    .rsp_value_o        (rsp_value),
    .rsp_err_o          (rsp_err),
    .esfa_willWrite_o   (esfa_willWrite),
    .esfa_isMetadata_o  (esfa_isMetadata),
    .esfa_new_index_o   (esfa_new_index),
    .esfa_new_value_o   (esfa_new_value),
    .esfa_metadata_o    (esfa_metadata),
    .esfa_selector_o    (esfa_selector),
    .esfa_resultBool_i  (esfa_resultBool),
    .esfa_resultValue_i (esfa_resultValue),
    .hit_count_o        (hit_count),
    .miss_count_o       (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] idx;
    logic [7:0] data;
    logic [7:0] sel;
    logic       res_bool;   // value presented by the ESFA during the query
    logic [7:0] res_val;
    logic       exp_bool;   // expected response fields (queries / reserved)
    logic [7:0] exp_val;
    logic       exp_err;
  } vec_t;

  vec_t vecs[9];

  int n_checks = 0;
  int n_fail   = 0;

  // expected ESFA write-side state (tracks "hold last value")
  logic [7:0] m_index = 8'h00, m_value = 8'h00, m_meta = 8'h00;
  logic       m_isMeta = 1'b0;
  int         m_hits = 0, m_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete the response handshake and confirm return to IDLE.
  task automatic drain_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string tag;
    int cyc;
    tag = $sformatf("v%0d", i);
    chk({tag, "_cmd_ready_pre"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_index = v.idx;
    cmd_data = v.data; cmd_selector = v.sel;
    esfa_resultBool = v.res_bool; esfa_resultValue = v.res_val;
    tick();
    cmd_valid = 1'b0;
    if (v.op == 2'b00 || v.op == 2'b01) begin
      m_index = v.idx; m_isMeta = v.op[0];
      if (v.op[0]) m_meta = v.data; else m_value = v.data;
      chk({tag, "_willWrite"}, 32'(esfa_willWrite), 32'd1);
      chk({tag, "_new_index"}, 32'(esfa_new_index), 32'(m_index));
      chk({tag, "_new_value"}, 32'(esfa_new_value), 32'(m_value));
      chk({tag, "_metadata"},  32'(esfa_metadata),  32'(m_meta));
      chk({tag, "_isMetadata"}, 32'(esfa_isMetadata), 32'(m_isMeta));
      chk({tag, "_cmd_ready_wr"}, 32'(cmd_ready), 32'd0);
      tick();
      chk({tag, "_willWrite_off"}, 32'(esfa_willWrite), 32'd0);
      chk({tag, "_cmd_ready_post"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_new_index_hold"}, 32'(esfa_new_index), 32'(m_index));
    end else if (v.op == 2'b10) begin
      chk({tag, "_selector"}, 32'(esfa_selector), 32'(v.sel));
      chk({tag, "_no_write_q"}, 32'(esfa_willWrite), 32'd0);
      cyc = 0;
      while (!rsp_valid && cyc < 20) begin
        tick();
        cyc++;
      end
      chk({tag, "_rsp_latency"}, 32'(cyc), 32'(SETTLE));
      chk({tag, "_rsp_bool"},  32'(rsp_bool),  32'(v.exp_bool));
      chk({tag, "_rsp_value"}, 32'(rsp_value), 32'(v.exp_val));
      chk({tag, "_rsp_err"},   32'(rsp_err),   32'(v.exp_err));
      chk({tag, "_cmd_ready_resp"}, 32'(cmd_ready), 32'd0);
      if (v.res_bool) m_hits++; else m_miss++;
      drain_rsp(tag);
      chk({tag, "_selector_hold"}, 32'(esfa_selector), 32'(v.sel));
    end else begin
      chk({tag, "_rsv_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_rsv_err"},   32'(rsp_err),   32'(v.exp_err));
      chk({tag, "_rsv_bool"},  32'(rsp_bool),  32'(v.exp_bool));
      chk({tag, "_rsv_value"}, 32'(rsp_value), 32'(v.exp_val));
      chk({tag, "_rsv_no_write"}, 32'(esfa_willWrite), 32'd0);
      drain_rsp(tag);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    //            op     idx    data   sel    rb    rv     eb    ev     ee
    vecs[0] = '{2'b00, 8'h03, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{2'b01, 8'h07, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{2'b10, 8'h00, 8'h00, 8'h03, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[3] = '{2'b10, 8'h00, 8'h00, 8'h07, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{2'b11, 8'h09, 8'h77, 8'h09, 1'b1, 8'h12, 1'b0, 8'hFF, 1'b1};
    vecs[5] = '{2'b10, 8'h00, 8'h00, 8'h20, 1'b1, 8'h11, 1'b1, 8'h11, 1'b0};
    vecs[6] = '{2'b10, 8'h00, 8'h00, 8'h21, 1'b0, 8'h42, 1'b0, 8'h42, 1'b0};
    vecs[7] = '{2'b10, 8'h00, 8'h00, 8'hC3, 1'b1, 8'hFE, 1'b1, 8'hFE, 1'b0};
    vecs[8] = '{2'b00, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_index = 8'h00;
    cmd_data = 8'h00; cmd_selector = 8'h00; rsp_ready = 1'b0;
    esfa_resultBool = 1'b0; esfa_resultValue = 8'h00;

    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_willWrite", 32'(esfa_willWrite), 32'd0);
    chk("rst_selector",  32'(esfa_selector), 32'd0);
    chk("rst_rsp_value", 32'(rsp_value), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);

    // Release; two zero-result edges later the controller is ready.
    reset_n = 1'b1;
    tick();
    chk("init_edge1_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("init_edge2_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    chk("stats_hit",  32'(hit_count),  STATS_EN ? 32'(m_hits) : 32'd0);
    chk("stats_miss", 32'(miss_count), STATS_EN ? 32'(m_miss) : 32'd0);

    // Backpressure: response must hold while the ESFA result changes and
    // new commands are offered.
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_selector = 8'h10;
    esfa_resultBool = 1'b1; esfa_resultValue = 8'h5A;
    tick();
    cmd_op = 2'b00; cmd_index = 8'h44; cmd_data = 8'h99;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("bp_latency", 32'(cyc), 32'(SETTLE));
    m_hits++;
    esfa_resultBool = 1'b0; esfa_resultValue = 8'h00;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp%0d_valid", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_value", k), 32'(rsp_value), 32'h5A);
      chk($sformatf("bp%0d_bool", k),  32'(rsp_bool),  32'd1);
      chk($sformatf("bp%0d_ready", k), 32'(cmd_ready), 32'd0);
      chk($sformatf("bp%0d_nowr", k),  32'(esfa_willWrite), 32'd0);
    end
    cmd_valid = 1'b0;
    drain_rsp("bp");
    chk("bp_value_retained", 32'(rsp_value), 32'h5A);
    chk("bp_index_untouched", 32'(esfa_new_index), 32'(m_index));
    chk("bp_stats_hit", 32'(hit_count), STATS_EN ? 32'(m_hits) : 32'd0);

    // Reset in the middle of a write strobe.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_index = 8'h55; cmd_data = 8'h66;
    tick();
    cmd_valid = 1'b0;
    chk("rw_strobe_on", 32'(esfa_willWrite), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rw_strobe_abort", 32'(esfa_willWrite), 32'd0);
    chk("rw_index_cleared", 32'(esfa_new_index), 32'd0);
    chk("rw_value_cleared", 32'(esfa_new_value), 32'd0);
    chk("rw_rsp_value_cleared", 32'(rsp_value), 32'd0);
    chk("rw_hit_cleared", 32'(hit_count), 32'd0);
    chk("rw_cmd_ready", 32'(cmd_ready), 32'd0);

    // Re-entry into INIT with a non-zero result: must stay not-ready.
    esfa_resultBool = 1'b1; esfa_resultValue = 8'h00;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("init_busy%0d", k), 32'(cmd_ready), 32'd0);
    end
    esfa_resultBool = 1'b0;
    tick();
    chk("init2_edge1_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("init2_edge2_ready", 32'(cmd_ready), 32'd1);
    chk("init2_selector", 32'(esfa_selector), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
